// File: rtl/work_packet_assembler.sv
// Assembles 64-byte UART work packets into midstate/data2 and pulses start on completion.
// Optional PACKET_CHECKSUM_EN: a 65th XOR checksum byte (XOR of bytes 0..63 ^ 8'h5A) gates the commit.
module work_packet_assembler #(
    parameter int PACKET_BYTES   = 64,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [255:0]         midstate,
    output logic [255:0]         data2,
    output logic                 start,
    output logic                 rx_busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    // state | meaning
    // IDLE  | no partial packet held, byte_cnt = 0
    // RECV  | bytes 1..63 being collected, inter-byte timer running
    // CSUM  | all 64 bytes held, waiting for the checksum byte
    typedef enum logic [1:0] {IDLE, RECV, CSUM} state_t;

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [6:0]      byte_cnt, byte_cnt_nxt;
    logic [TO_W-1:0] tcnt, tcnt_nxt;
    logic [511:0]    shadow, shadow_nxt;
    logic            commit, discard;
`ifdef PACKET_CHECKSUM_EN
    logic [7:0]      csum, csum_nxt;
`endif

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        tcnt_nxt     = tcnt;
        shadow_nxt   = shadow;
        commit       = 1'b0;
        discard      = 1'b0;
`ifdef PACKET_CHECKSUM_EN
        csum_nxt     = csum;
`endif
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    shadow_nxt[7:0] = rx_data;
`ifdef PACKET_CHECKSUM_EN
                    csum_nxt        = rx_data;
`endif
                    byte_cnt_nxt    = 7'd1;
                    tcnt_nxt        = '0;
                    state_nxt       = RECV;
                end
            end
            RECV, CSUM: begin
                if (rx_valid) begin
                    // a byte landing on the last timer count is still in time
                    tcnt_nxt = '0;
                    if (state == CSUM) begin
                        byte_cnt_nxt = '0;
                        state_nxt    = IDLE;
`ifdef PACKET_CHECKSUM_EN
                        commit       = (rx_data == (csum ^ 8'h5A));
                        discard      = !commit;
`endif
                    end else begin
                        shadow_nxt[int'(byte_cnt[5:0])*8 +: 8] = rx_data;
`ifdef PACKET_CHECKSUM_EN
                        csum_nxt = csum ^ rx_data;
`endif
                        if (byte_cnt == 7'(PACKET_BYTES - 1)) begin
`ifdef PACKET_CHECKSUM_EN
                            byte_cnt_nxt = byte_cnt + 7'd1;
                            state_nxt    = CSUM;
`else
                            byte_cnt_nxt = '0;
                            state_nxt    = IDLE;
                            commit       = 1'b1;
`endif
                        end else begin
                            byte_cnt_nxt = byte_cnt + 7'd1;
                        end
                    end
                end else if (tcnt == TO_LAST) begin
                    byte_cnt_nxt = '0;
                    tcnt_nxt     = '0;
                    state_nxt    = IDLE;
                    discard      = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            tcnt      <= '0;
            shadow    <= '0;
            midstate  <= '0;
            data2     <= '0;
            start     <= 1'b0;
            rx_busy   <= 1'b0;
            err_count <= '0;
`ifdef PACKET_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            tcnt     <= tcnt_nxt;
            shadow   <= shadow_nxt;
            start    <= commit;
            rx_busy  <= (byte_cnt_nxt != 7'd0);
`ifdef PACKET_CHECKSUM_EN
            csum     <= csum_nxt;
`endif
            // shadow_nxt already holds the final byte, so commit costs no extra cycle
            if (commit) begin
                midstate <= shadow_nxt[255:0];
                data2    <= shadow_nxt[511:256];
            end
            if (discard && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_work_packet_assembler.sv
// Scoreboard bench for work_packet_assembler: a packet-level reference model queues expected commits.
module tb_work_packet_assembler;
    localparam int T  = 16;
    localparam int PB = 64;
`ifdef PACKET_CHECKSUM_EN
    localparam int FB = 65;
`else
    localparam int FB = 64;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [255:0] midstate, data2;
    logic         start, rx_busy;
    logic [7:0]   err_count;

    work_packet_assembler #(.PACKET_BYTES(64), .TIMEOUT_CYCLES(T), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .midstate(midstate), .data2(data2), .start(start), .rx_busy(rx_busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] m;
        logic [255:0] d;
        logic [7:0]   e;
    } exp_t;

    exp_t         sb[$];
    logic [7:0]   pkt[$];
    int           idle_run = 0;
    logic [7:0]   m_err = 0;
    logic [255:0] m_mid = 0, m_d2 = 0;
    int           errors = 0, checks = 0;
    int           cyc = 0;
    int           start_cyc[$];
    logic         prev_start = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    function automatic void err_inc();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endfunction

    function automatic void model_settle();
        if (pkt.size() != 0 && idle_run >= T) begin
            pkt.delete();
            err_inc();
        end
    endfunction

    function automatic void model_byte(input logic [7:0] d);
        logic [7:0] x;
        bit ok;
        exp_t e;
        model_settle();
        pkt.push_back(d);
        idle_run = 0;
        if (pkt.size() == FB) begin
            x = 8'h5A;
            for (int i = 0; i < PB; i++) x = x ^ pkt[i];
            ok = 1'b1;
            if (FB > PB) ok = (x == pkt[FB-1]);
            if (ok) begin
                for (int i = 0; i < 32; i++) begin
                    e.m[8*i +: 8] = pkt[i];
                    e.d[8*i +: 8] = pkt[32+i];
                end
                e.e = m_err;
                sb.push_back(e);
                m_mid = e.m;
                m_d2  = e.d;
            end else begin
                err_inc();
            end
            pkt.delete();
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        if (v) model_byte(d);
        else idle_run++;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        idle(gap);
        cycle(1'b1, d);
    endtask

    task automatic send_pkt(input bit incr, input int gap_max);
        logic [7:0] x, b;
        x = 8'h5A;
        for (int k = 0; k < PB; k++) begin
            b = incr ? 8'(k) : 8'($urandom);
            x = x ^ b;
            send_byte(b, (k == 0) ? 0 : int'($urandom_range(0, gap_max)));
        end
        if (FB > PB) send_byte(x, int'($urandom_range(0, gap_max)));
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) cycle(1'b0, 8'h00);
        chk("scoreboard_drained", 256'(sb.size()), 256'd0);
    endtask

    task automatic check_hold(input string tag);
        drain();
        model_settle();
        chk({tag, "_midstate"}, midstate, m_mid);
        chk({tag, "_data2"}, data2, m_d2);
        chk({tag, "_err_count"}, 256'(err_count), 256'(m_err));
        chk({tag, "_rx_busy"}, 256'(rx_busy), 256'(pkt.size() != 0));
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst_midstate", midstate, 256'd0);
        chk("rst_data2", data2, 256'd0);
        chk("rst_start", 256'(start), 256'd0);
        chk("rst_rx_busy", 256'(rx_busy), 256'd0);
        chk("rst_err_count", 256'(err_count), 256'd0);
        pkt.delete();
        sb.delete();
        idle_run = 0;
        m_err = 0;
        m_mid = 0;
        m_d2  = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset && start) begin
            exp_t e;
            start_cyc.push_back(cyc);
            if (prev_start) begin
                checks++;
                errors++;
                $display("FAIL start_consecutive: start high two cycles in a row");
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_start: start=1 with no packet expected");
            end else begin
                e = sb.pop_front();
                chk("sb_midstate", midstate, e.m);
                chk("sb_data2", data2, e.d);
                chk("sb_err_count", 256'(err_count), 256'(e.e));
            end
        end
        prev_start = reset ? 1'b0 : start;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int r, n;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        do_reset();

        // incrementing packet, back-to-back bytes
        send_pkt(1'b1, 0);
        drain();
        chk("t1_ms_lo", 256'(midstate[7:0]), 256'h00);
        chk("t1_ms_hi", 256'(midstate[255:248]), 256'h1F);
        chk("t1_d2_lo", 256'(data2[7:0]), 256'h20);
        chk("t1_d2_hi", 256'(data2[255:248]), 256'h3F);
        chk("t1_d2_b28", 256'(data2[231:224]), 256'h3C);
        chk("t1_err", 256'(err_count), 256'd0);

        // partial packet then timeout
        for (int k = 0; k < 20; k++) send_byte(8'($urandom), 0);
        idle(T);
        check_hold("t2");
        chk("t2_err_one", 256'(err_count), 256'd1);
        send_pkt(1'b0, 2);
        check_hold("t2b");

        // byte on the last allowed timer count is still accepted
        for (int k = 0; k < 10; k++) send_byte(8'($urandom), 0);
        send_byte(8'hA5, T - 1);
        for (int k = 11; k < FB; k++) send_byte(8'($urandom), (k == 40) ? T - 1 : 0);
        check_hold("t3");

        // back-to-back packets, byte 0 of the second in the commit cycle
        start_cyc.delete();
        send_pkt(1'b0, 0);
        send_pkt(1'b0, 0);
        drain();
        chk("t5_two_starts", 256'(start_cyc.size()), 256'd2);
        if (start_cyc.size() == 2)
            chk("t5_spacing", 256'(start_cyc[1] - start_cyc[0]), 256'(FB));

        // reset in the middle of a packet
        for (int k = 0; k < 40; k++) send_byte(8'($urandom), 0);
        do_reset();
        send_pkt(1'b1, 1);
        check_hold("t4");

        // randomized mix of clean, slow, truncated and timed-out traffic
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                send_pkt(1'b0, int'($urandom_range(0, 3)));
            end else if (r == 6) begin
                send_pkt(1'b0, T - 1);
            end else begin
                n = int'($urandom_range(1, FB - 1));
                for (int k = 0; k < n; k++) send_byte(8'($urandom), int'($urandom_range(0, 2)));
                idle(T + int'($urandom_range(0, 3)) - ((r == 9) ? 1 : 0));
            end
        end
        check_hold("rand");

        // error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_byte(8'($urandom), 0);
            idle(T);
        end
        check_hold("sat");
        chk("sat_ff", 256'(err_count), 256'hFF);

`ifdef PACKET_CHECKSUM_EN
        do_reset();
        for (int k = 0; k < PB; k++) send_byte(8'h00, 0);
        send_byte(8'h5A, 0);
        check_hold("cs_good");
        for (int k = 0; k < PB; k++) send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_hold("cs_bad");
        chk("cs_bad_err", 256'(err_count), 256'd1);
`endif

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/work_packet_assembler.md
Name: work_packet_assembler

Overview:
- Upstream neighbour of the DCM/command controller.
- Takes the byte stream from the UART receiver and assembles 64-byte work packets into the 256-bit midstate and data2 buses.
- Pulses start for one cycle when a complete, valid packet has been captured.
- Discards partial packets on an inter-byte timeout, so a dropped byte never shifts every later packet.

Parameters:
- PACKET_BYTES, 64, bytes per packet: 32 midstate followed by 32 data2. Fixed at 64; other values unsupported.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between consecutive bytes of one packet.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock (same domain as the consumer's clk).
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid while it is high. No backpressure.
- midstate  output  256  midstate of the last complete packet.
- data2  output  256  data2 of the last complete packet.
- start  output  1  one-cycle pulse; midstate and data2 were updated this cycle.
- rx_busy  output  1  high while a packet is partially received (byte_cnt != 0).
- err_count  output  ERR_CNT_W  saturating count of discarded packets.

Behaviour:
- Reset (async assert, sync release): midstate=0, data2=0, start=0, rx_busy=0, err_count=0, byte_cnt=0, timeout counter=0, shadow buffer=0.
- Byte placement: packet byte k (0-based) goes to shadow[8k+7:8k].
  - k=0..31 fill the midstate shadow; k=32..63 fill the data2 shadow (byte index k-32).
  - Example: data2 byte 28 lands in data2[231:224].
- Shadow vs outputs: bytes fill a shadow buffer. midstate and data2 change only on packet completion and hold their value otherwise, so the consumer never sees a torn packet.
- States:
  - IDLE (byte_cnt=0): rx_valid stores the byte at k=0 and moves to RECV with byte_cnt=1.
  - RECV: each rx_valid stores the byte at k=byte_cnt and increments byte_cnt.
  - COMMIT: when the byte at k=63 is accepted (cycle N), then at cycle N+1 the shadow is copied to midstate/data2, start=1, and byte_cnt=0. Latency from last-byte strobe to start is 1 cycle.
- Byte in commit cycle: an rx_valid during the commit cycle (N+1) is accepted as byte 0 of the next packet. No byte is lost.
- Timeout:
  - A counter runs only in RECV. It clears on every accepted byte and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 without rx_valid: byte_cnt=0, shadow discarded, err_count increments (saturating at all-ones), counter clears. No start pulse; outputs unchanged.
- Timeout vs byte collision: rx_valid in the same cycle the counter reaches TIMEOUT_CYCLES-1 counts as an in-time byte. No timeout occurs; the byte is stored normally.
- start is high for exactly one cycle per completed packet and is never high in consecutive cycles.
- rx_busy = (byte_cnt != 0), registered.
- Reset mid-packet: partial data discarded, all outputs return to reset values immediately (async).
- Outputs are registered; there is no combinational path from rx_* to any output.

Optional Feature:
- Macro: PACKET_CHECKSUM_EN.
- Defined:
  - A 65th byte follows each packet. It must equal the XOR of bytes 0..63 XOR 8'h5A.
  - Commit happens one cycle after the checksum byte, and only on a match.
  - On mismatch: packet discarded, err_count increments, no start pulse, outputs unchanged.
  - The timeout also applies between byte 63 and the checksum byte.
- Undefined: no checksum byte; commit occurs after byte 63 as described above.

Test Plan:
- Send 64 bytes, values 0x00..0x3F, back-to-back (rx_valid every cycle) -> one cycle after the last byte: start=1 for 1 cycle, midstate[7:0]=0x00, midstate[255:248]=0x1F, data2[7:0]=0x20, data2[255:248]=0x3F, err_count=0.
- Send 20 bytes, then idle for TIMEOUT_CYCLES -> rx_busy falls, err_count=1, no start, outputs still hold the previous packet. A following full packet then commits correctly.
- With TIMEOUT_CYCLES=16, deliver a byte exactly on cycle 15 of the gap -> accepted, no error; a 64-byte packet completes with start=1.
- Assert reset after byte 40 -> all outputs 0 immediately; a new 64-byte packet commits with the correct byte mapping.
- Two packets back-to-back, with byte 0 of packet 2 strobed in the commit cycle of packet 1 -> two start pulses 64 cycles apart, both packets correct.
- PACKET_CHECKSUM_EN: all-zero packet with checksum 0x5A -> start=1; with checksum 0x00 -> no start, err_count=1. Inject 300 errors with ERR_CNT_W=8 -> err_count saturates at 0xFF.
